// File: rtl/shift_add_multiplier_8.sv
// shift_add_multiplier_8: sequential 8x8 unsigned multiplier, one add-and-shift per cycle
// through an 8-bit carry-look-ahead adder, with start/busy/done handshake.
module cla_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       pp;
    assign g = a & b;
    assign p = a ^ b;
    // Each carry is formed directly from generate/propagate terms, not rippled.
    always_comb begin
        c = '0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end
    assign s  = p ^ c[7:0];
    assign co = c[8];
endmodule

module shift_add_multiplier_8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done,
    output logic        zero
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d, q_q, q_d, acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic        zero_q, zero_d, done_q, done_d;
    logic [7:0]  sum;
    logic        co;
    logic [8:0]  add;

    cla_adder_8 u_add (.a(acc_q), .b(m_q), .cin(1'b0), .s(sum), .co(co));

    // Carry-out lands in ACC[7] after the shift, so no separate carry register is kept.
    assign add = q_q[0] ? {co, sum} : {1'b0, acc_q};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                m_d     = A;
                q_d     = B;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
        end else begin
            {acc_d, q_d} = {add, q_q[7:1]};
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                p_d     = {add, q_q[7:1]};
                zero_d  = (p_d == 16'h0000);
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign P    = p_q;
    assign zero = zero_q;
    assign done = done_q;
    assign busy = (state_q == RUN);
endmodule

// File: tb/tb_shift_add_multiplier_8.sv
// tb_shift_add_multiplier_8: directed vectors with hand-computed products,
// checking reset, latency, busy/done handshake and result holding.
module tb_shift_add_multiplier_8;
    logic        clk, reset_n, start;
    logic [7:0]  A, B;
    logic [15:0] P;
    logic        busy, done, zero;
    int          tests = 0, fails = 0, done_cnt = 0, snap;

    shift_add_multiplier_8 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B),
        .P(P), .busy(busy), .done(done), .zero(zero)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input logic [15:0] prev, input string tag);
        A = a; B = b; start = 1;
        tick;
        start = 0;
        check({tag, " busy@N"}, 16'(busy), 16'd1);
        for (int i = 1; i < 8; i++) begin
            check({tag, " hold P"}, P, prev);
            tick;
            check({tag, " busy"}, 16'(busy), 16'd1);
            check({tag, " done low"}, 16'(done), 16'd0);
        end
        tick;
        check({tag, " done"}, 16'(done), 16'd1);
        check({tag, " busy off"}, 16'(busy), 16'd0);
        check({tag, " P"}, P, exp);
        check({tag, " zero"}, 16'(zero), 16'(exp == 16'h0000));
    endtask

    initial begin
        reset_n = 0; start = 0; A = 0; B = 0;
        tick; tick;
        check("rst P", P, 16'h0000);
        check("rst zero", 16'(zero), 16'd1);
        check("rst busy", 16'(busy), 16'd0);
        check("rst done", 16'(done), 16'd0);
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("idle P", P, 16'h0000);
            check("idle busy", 16'(busy), 16'd0);
            check("idle done", 16'(done), 16'd0);
        end

        snap = done_cnt;
        run_mul(8'h0D, 8'h0B, 16'h008F, 16'h0000, "0Dx0B");
        tick;
        check("0Dx0B done pulse", 16'(done), 16'd0);
        check("0Dx0B one done", 16'(done_cnt - snap), 16'd1);

        run_mul(8'hFF, 8'hFF, 16'hFE01, 16'h008F, "FFxFF");
        tick;
        run_mul(8'h80, 8'h02, 16'h0100, 16'hFE01, "80x02");
        tick;
        run_mul(8'h00, 8'hA5, 16'h0000, 16'h0100, "00xA5");
        tick;

        // start requests during RUN must be ignored
        snap = done_cnt;
        A = 8'h03; B = 8'h05; start = 1;
        tick;
        start = 0;
        tick; tick;
        A = 8'hFF; B = 8'hFF; start = 1;
        tick;
        start = 0;
        tick;
        start = 1;
        tick;
        start = 0;
        tick; tick;
        check("sb done early", 16'(done), 16'd0);
        tick;
        check("sb done", 16'(done), 16'd1);
        check("sb P", P, 16'h000F);
        tick;
        check("sb idle", 16'(busy), 16'd0);
        tick; tick;
        check("sb one done", 16'(done_cnt - snap), 16'd1);
        check("sb P kept", P, 16'h000F);

        run_mul(8'h12, 8'h34, 16'h03A8, 16'h000F, "12x34");
        run_mul(8'h10, 8'h10, 16'h0100, 16'h03A8, "b2b 10x10");
        tick;

        // reset in the middle of an operation
        snap = done_cnt;
        A = 8'hFF; B = 8'hFF; start = 1;
        tick;
        start = 0;
        tick; tick; tick;
        reset_n = 0;
        tick;
        reset_n = 1;
        check("mid rst busy", 16'(busy), 16'd0);
        check("mid rst P", P, 16'h0000);
        check("mid rst zero", 16'(zero), 16'd1);
        for (int i = 0; i < 8; i++) tick;
        check("mid rst no done", 16'(done_cnt - snap), 16'd0);
        check("mid rst P held", P, 16'h0000);
        run_mul(8'h02, 8'h03, 16'h0006, 16'h0000, "02x03");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
